// File: rtl/utils_lifo_pkg.sv
// Shared types and helpers for the checkpointed LIFO.
package utils_lifo_pkg;

    typedef enum logic [1:0] {
        LIFO_NONE,
        LIFO_PUSH,
        LIFO_POP,
        LIFO_REPLACE
    } lifo_op_e;

    // Width of an index into n items, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/utils_lifo_ckpt_bank.sv
// Snapshot register file: one synchronous write port, one combinational read port.
module utils_lifo_ckpt_bank #(
    parameter int SNAP_W   = 8,
    parameter int NUM_CKPT = 4,
    parameter int ID_W     = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic [ID_W-1:0]   wr_id_i,
    input  logic [SNAP_W-1:0] wr_data_i,
    input  logic [ID_W-1:0]   rd_id_i,
    output logic [SNAP_W-1:0] rd_data_o
);

    logic [SNAP_W-1:0] slot_q [NUM_CKPT];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_CKPT; i++) slot_q[i] <= '0;
        end else if (wr_en_i && (int'(wr_id_i) < NUM_CKPT)) begin
            slot_q[wr_id_i] <= wr_data_i;
        end
    end

    // Reading the register array gives the pre-write contents on a same-slot save.
    always_comb begin
        rd_data_o = '0;
        if (int'(rd_id_i) < NUM_CKPT) rd_data_o = slot_q[rd_id_i];
    end

endmodule

// File: rtl/utils_lifo_ckpt.sv
// LIFO with same-cycle push/pop/replace and single-cycle checkpoint restore.
module utils_lifo_ckpt
    import utils_lifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter bit OVERWRITE = 1'b1,
    parameter int NUM_CKPT  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              push_data_i,
    input  logic                          pop_i,
    output logic [WIDTH-1:0]              top_data_o,
    output logic                          top_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          overflow_o,
    output logic                          underflow_o,
    input  logic                          ckpt_save_i,
    input  logic [id_width(NUM_CKPT)-1:0] ckpt_save_id_i,
    input  logic                          ckpt_restore_i,
    input  logic [id_width(NUM_CKPT)-1:0] ckpt_restore_id_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ID_W  = id_width(NUM_CKPT);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [PTR_W-1:0] ptr;
        logic [CNT_W-1:0] cnt;
        logic [WIDTH-1:0] top;
    } snap_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_m1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic             is_full, is_empty;
    lifo_op_e         op;
    snap_t            save_snap, rest_snap;

    assign ptr_m1    = ptr_q - PTR_ONE;
    assign is_full   = (cnt_q == CNT_FULL);
    assign is_empty  = (cnt_q == '0);
    assign save_snap = '{ptr: ptr_q, cnt: cnt_q, top: mem_q[ptr_m1]};

    utils_lifo_ckpt_bank #(
        .SNAP_W  ($bits(snap_t)),
        .NUM_CKPT(NUM_CKPT),
        .ID_W    (ID_W)
    ) u_bank (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .wr_en_i  (ckpt_save_i),
        .wr_id_i  (ckpt_save_id_i),
        .wr_data_i(save_snap),
        .rd_id_i  (ckpt_restore_id_i),
        .rd_data_o(rest_snap)
    );

    // push_i/pop_i are one-cycle requests with no backpressure: the stack always
    // consumes them, and refusal shows up only as an overflow/underflow pulse.
    always_comb begin
        op = LIFO_NONE;
        if (push_i && pop_i) op = LIFO_REPLACE;
        else if (push_i)     op = LIFO_PUSH;
        else if (pop_i)      op = LIFO_POP;
    end

    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = push_data_i;
        if (flush_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (ckpt_restore_i) begin
            // Re-write the saved top in case a later push clobbered it.
            ptr_d     = rest_snap.ptr;
            cnt_d     = rest_snap.cnt;
            mem_we    = (rest_snap.cnt != '0);
            mem_waddr = rest_snap.ptr - PTR_ONE;
            mem_wdata = rest_snap.top;
        end else begin
            case (op)
                LIFO_PUSH: begin
                    ovf_d = is_full;
                    if (!is_full || OVERWRITE) begin
                        mem_we = 1'b1;
                        ptr_d  = ptr_q + PTR_ONE;
                    end
                    if (!is_full) cnt_d = cnt_q + CNT_ONE;
                end
                LIFO_POP: begin
                    unf_d = is_empty;
                    if (!is_empty) begin
                        ptr_d = ptr_m1;
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                LIFO_REPLACE: begin
                    mem_we = 1'b1;
                    if (is_empty) begin
                        unf_d = 1'b1;
                        ptr_d = ptr_q + PTR_ONE;
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        mem_waddr = ptr_m1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (mem_we) mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign top_data_o  = mem_q[ptr_m1];
    assign top_valid_o = !is_empty;
    assign count_o     = cnt_q;
    assign full_o      = is_full;
    assign empty_o     = is_empty;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: tb/tb_utils_lifo_ckpt.sv
// Bench: two 8x4 stacks (overwrite / drop) driven identically, checked against a reference model.
module tb_utils_lifo_ckpt;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0, push = 1'b0, pop = 1'b0;
    logic [7:0] data = '0;
    logic       sv = 1'b0, rs = 1'b0;
    logic [1:0] sid = '0, rid = '0;

    logic [7:0] top0, top1;
    logic [2:0] cnt0, cnt1;
    logic       tv0, tv1, full0, full1, empty0, empty1, ovf0, ovf1, unf0, unf1;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    // Per instance k (0 = overwrite, 1 = drop): entries, pointer, count, slots.
    int         m_ptr [2];
    int         m_cnt [2];
    logic [7:0] m_mem [2][4];
    int         s_ptr [2][4];
    int         s_cnt [2][4];
    logic [7:0] s_top [2][4];

    utils_lifo_ckpt #(.WIDTH(8), .DEPTH(4), .OVERWRITE(1'b1), .NUM_CKPT(4)) dut_ow (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .push_i(push), .push_data_i(data),
        .pop_i(pop), .top_data_o(top0), .top_valid_o(tv0), .count_o(cnt0), .full_o(full0),
        .empty_o(empty0), .overflow_o(ovf0), .underflow_o(unf0), .ckpt_save_i(sv),
        .ckpt_save_id_i(sid), .ckpt_restore_i(rs), .ckpt_restore_id_i(rid)
    );

    utils_lifo_ckpt #(.WIDTH(8), .DEPTH(4), .OVERWRITE(1'b0), .NUM_CKPT(4)) dut_drop (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .push_i(push), .push_data_i(data),
        .pop_i(pop), .top_data_o(top1), .top_valid_o(tv1), .count_o(cnt1), .full_o(full1),
        .empty_o(empty1), .overflow_o(ovf1), .underflow_o(unf1), .ckpt_save_i(sv),
        .ckpt_save_id_i(sid), .ckpt_restore_i(rs), .ckpt_restore_id_i(rid)
    );

    logic [15:0] obs0, obs1;
    assign obs0 = {tv0, cnt0, full0, empty0, ovf0, unf0, top0};
    assign obs1 = {tv1, cnt1, full1, empty1, ovf1, unf1, top1};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0;
            m_cnt[k] = 0;
            for (int i = 0; i < 4; i++) begin
                m_mem[k][i] = '0;
                s_ptr[k][i] = 0;
                s_cnt[k][i] = 0;
                s_top[k][i] = '0;
            end
        end
    endtask

    task automatic model_step(input int k, output logic [15:0] e);
        int         optr = m_ptr[k];
        int         ocnt = m_cnt[k];
        logic [7:0] otop = m_mem[k][(optr + 3) % 4];
        int         rp   = s_ptr[k][rid];
        int         rc   = s_cnt[k][rid];
        logic [7:0] rt   = s_top[k][rid];
        bit         ov   = 1'b0;
        bit         un   = 1'b0;
        if (flush) begin
            m_ptr[k] = 0;
            m_cnt[k] = 0;
        end else if (rs) begin
            m_ptr[k] = rp;
            m_cnt[k] = rc;
            if (rc != 0) m_mem[k][(rp + 3) % 4] = rt;
        end else if (push && pop) begin
            if (ocnt > 0) m_mem[k][(optr + 3) % 4] = data;
            else begin
                m_mem[k][optr] = data;
                m_ptr[k] = (optr + 1) % 4;
                m_cnt[k] = 1;
                un = 1'b1;
            end
        end else if (push) begin
            if (ocnt < 4) begin
                m_mem[k][optr] = data;
                m_ptr[k] = (optr + 1) % 4;
                m_cnt[k] = ocnt + 1;
            end else begin
                ov = 1'b1;
                if (k == 0) begin
                    m_mem[k][optr] = data;
                    m_ptr[k] = (optr + 1) % 4;
                end
            end
        end else if (pop) begin
            if (ocnt > 0) begin
                m_ptr[k] = (optr + 3) % 4;
                m_cnt[k] = ocnt - 1;
            end else un = 1'b1;
        end
        if (sv) begin
            s_ptr[k][sid] = optr;
            s_cnt[k][sid] = ocnt;
            s_top[k][sid] = otop;
        end
        e = {m_cnt[k] != 0, 3'(m_cnt[k]), m_cnt[k] == 4, m_cnt[k] == 0, ov, un,
             m_mem[k][(m_ptr[k] + 3) % 4]};
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit f, input bit ps, input logic [7:0] d, input bit pp,
                         input bit s, input logic [1:0] si, input bit r, input logic [1:0] ri);
        logic [15:0] e0, e1;
        @(negedge clk);
        flush = f; push = ps; data = d; pop = pp;
        sv = s; sid = si; rs = r; rid = ri;
        model_step(0, e0);
        model_step(1, e1);
        exp_q.push_back({e1, e0});
    endtask

    task automatic do_push(input logic [7:0] d); drive(0, 1, d, 0, 0, 0, 0, 0); endtask
    task automatic do_pop();                     drive(0, 0, 0, 1, 0, 0, 0, 0); endtask
    task automatic do_repl(input logic [7:0] d); drive(0, 1, d, 1, 0, 0, 0, 0); endtask
    task automatic do_flush();                   drive(1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_idle();                    drive(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_save(input logic [1:0] i); drive(0, 0, 0, 0, 1, i, 0, 0); endtask
    task automatic do_rest(input logic [1:0] i); drive(0, 0, 0, 0, 0, 0, 1, i); endtask

    task automatic check_reset(input string name, input logic [15:0] act);
        checks++;
        if (act[15:8] != 8'b0_000_0100) begin
            errors++;
            $display("FAIL %s: flags/count got %b, want %b", name, act[15:8], 8'b0_000_0100);
        end
    endtask

    // Asynchronous reset landing in the middle of a push cycle.
    task automatic reset_mid_burst(input logic [7:0] d);
        @(negedge clk);
        flush = 0; push = 1; data = d; pop = 0; sv = 1; sid = 2'd3; rs = 0;
        #2 rst_n = 1'b0;
        #1;
        check_reset("async_reset_ow", obs0);
        check_reset("async_reset_drop", obs1);
        push = 0; sv = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic check_obs(input string name, input logic [15:0] act, input logic [15:0] e);
        bit bad;
        checks++;
        bad = (act[15:8] != e[15:8]) || (e[15] && (act[7:0] != e[7:0]));
        if (bad) begin
            errors++;
            $display("FAIL %s @%0t: {valid,count,full,empty,ovf,unf} got %b want %b, top got %h want %h",
                     name, $time, act[15:8], e[15:8], act[7:0], e[7:0]);
        end
    endtask

    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_obs("stack_ow", obs0, e[15:0]);
                check_obs("stack_drop", obs1, e[31:16]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        @(negedge clk);
        #1;
        check_reset("reset_ow", obs0);
        check_reset("reset_drop", obs1);
        @(negedge clk);
        rst_n = 1'b1;

        do_push(8'h11); do_push(8'h22); do_push(8'h33);
        do_pop(); do_pop();
        do_flush();

        for (int i = 1; i <= 5; i++) do_push(8'(i));
        do_idle();
        repeat (4) do_pop();
        do_pop();
        do_pop();

        do_flush();
        do_push(8'hA0); do_push(8'hB0);
        do_repl(8'hC0);
        do_flush();
        do_repl(8'hD0);
        do_push(8'hE0); do_push(8'hE1); do_push(8'hE2);
        do_repl(8'hE3);

        do_flush();
        do_push(8'h10); do_push(8'h20);
        do_save(2'd2);
        do_pop(); do_push(8'h99); do_push(8'h77);
        do_rest(2'd2);
        do_pop();
        do_pop();

        drive(1, 1, 8'h55, 0, 0, 0, 0, 0);
        do_push(8'h31); do_push(8'h32);
        do_save(2'd1);
        do_push(8'h33);
        drive(0, 0, 0, 1, 0, 0, 1, 2'd1);
        do_push(8'h34); do_push(8'h35);
        drive(0, 0, 0, 0, 1, 2'd1, 1, 2'd1);
        do_pop();
        do_rest(2'd1);
        drive(1, 0, 0, 0, 0, 0, 1, 2'd1);
        do_push(8'h41); do_push(8'h42);
        reset_mid_burst(8'h43);
        do_idle();
        do_rest(2'd3);
        do_push(8'h44);

        for (int n = 0; n < 400; n++) begin
            int r;
            bit f, ps, pp, s, rr;
            r  = $urandom_range(0, 99);
            f  = (r < 3);
            rr = (r >= 3 && r < 11);
            ps = ($urandom_range(0, 99) < 50);
            pp = ($urandom_range(0, 99) < 40);
            s  = ($urandom_range(0, 99) < 12);
            drive(f, ps, 8'($urandom), pp, s, 2'($urandom_range(0, 3)),
                  rr, 2'($urandom_range(0, 3)));
            if (n == 200) reset_mid_burst(8'($urandom));
        end
        do_idle();

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries never compared, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/utils_lifo_ckpt.md
Name: utils_lifo_ckpt

Overview:
Parametrised synchronous last-in-first-out stack with checkpoint/restore, for return-address prediction and other speculative stacks.
- Push, pop and push+pop (replace top) are supported in the same cycle.
- Overflow policy is selectable: overwrite the oldest entry, or drop the push.
- NUM_CKPT snapshot slots let the pipeline roll the stack back after a misprediction in one cycle.

Parameters:
WIDTH, 32, data width in bits
DEPTH, 16, number of entries; power of two, at least 2
OVERWRITE, 1, 1: push when full overwrites the oldest entry; 0: push when full is dropped
NUM_CKPT, 4, number of checkpoint slots, at least 1

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
flush_i  in  1  empty the stack; entry contents are kept
push_i  in  1  push request
push_data_i  in  WIDTH  data to push
pop_i  in  1  pop request
top_data_o  out  WIDTH  current top entry (combinational peek)
top_valid_o  out  1  stack not empty
count_o  out  $clog2(DEPTH+1)  number of valid entries
full_o  out  1  count_o == DEPTH
empty_o  out  1  count_o == 0
overflow_o  out  1  one-cycle pulse, registered, one cycle after a push while full
underflow_o  out  1  one-cycle pulse, registered, one cycle after a pop while empty
ckpt_save_i  in  1  save a snapshot
ckpt_save_id_i  in  $clog2(NUM_CKPT) (min 1)  slot to save into
ckpt_restore_i  in  1  restore a snapshot
ckpt_restore_id_i  in  $clog2(NUM_CKPT) (min 1)  slot to restore from

Behaviour:
- State: entry array mem[DEPTH], ptr (log2 DEPTH bits, wraps modulo DEPTH), cnt (0..DEPTH).
- Top entry is mem[ptr-1]. top_data_o = mem[ptr-1] whenever cnt != 0; otherwise don't-care (bench ignores it).
- Reset: ptr=0, cnt=0, all mem and checkpoint slots 0, overflow_o=0, underflow_o=0. Outputs therefore reset to empty_o=1, full_o=0, count_o=0, top_valid_o=0.
- Priority per cycle: flush_i > ckpt_restore_i > push/pop. A lower-priority request in the same cycle is ignored and raises no pulse.
- Flush: cnt<=0, ptr<=0.
- Push only, not full: mem[ptr]<=data, ptr+1, cnt+1.
- Push only, full, OVERWRITE=1: mem[ptr]<=data, ptr+1, cnt stays DEPTH, overflow_o=1 next cycle.
- Push only, full, OVERWRITE=0: no write, no change, overflow_o=1 next cycle.
- Pop only, not empty: ptr-1, cnt-1. Entry contents are not cleared.
- Pop only, empty: no change, underflow_o=1 next cycle.
- Push+pop, not empty: replace, i.e. mem[ptr-1]<=data; ptr and cnt unchanged. Applies also when full, with no overflow.
- Push+pop, empty: acts as a plain push, underflow_o=1 next cycle.
- Checkpoint save: slot[id] <= {ptr, cnt, mem[ptr-1]}. The snapshot is the pre-update state of the same cycle. Save is honoured in parallel with any op, including flush and restore.
- Save and restore of the same slot in the same cycle: restore uses the old slot contents; the slot then holds the new snapshot.
- Checkpoint restore: ptr<=slot.ptr, cnt<=slot.cnt. If slot.cnt != 0, also mem[slot.ptr-1]<=slot.top, repairing a top entry overwritten by a later push.
- Restore guarantees only the top entry. Deeper entries overwritten after the save are not recovered; this is accepted behaviour.
- Restore takes effect next cycle: top_data_o, count_o and flags reflect the snapshot one cycle after ckpt_restore_i.
- All state updates on posedge clk_i. Asynchronous reset mid-operation drops everything to reset values immediately. No partial write survives reset.

Decomposition:
- Package utils_lifo_pkg:
  - enum lifo_op_e {LIFO_NONE, LIFO_PUSH, LIFO_POP, LIFO_REPLACE} for the decoded per-cycle op.
  - Function to compute max(1, clog2(n)) for id widths.
- Snapshot struct {ptr, cnt, top} is declared locally in the module, because it is width-parametrised.
- One sub-module, utils_lifo_ckpt_bank: NUM_CKPT x snapshot register file with one write port (save) and one combinational read port (restore), async reset.

Test Plan:
1. WIDTH=8, DEPTH=4. Push 0x11, 0x22, 0x33 -> count_o=3, top_data_o=0x33. Pop twice -> top_data_o=0x11, count_o=1.
2. OVERWRITE=1. Push 0x01..0x05 -> overflow_o pulses once, one cycle after the 5th push; count_o=4, full_o=1. Four pops return 0x05, 0x04, 0x03, 0x02 -> empty_o=1.
3. OVERWRITE=0. Same stimulus -> 5th push dropped, overflow_o pulse, top stays 0x04. Pop on empty -> underflow_o pulse, count_o stays 0.
4. Stack {0xA0, 0xB0}, push+pop with 0xC0 -> count_o=2, top_data_o=0xC0. On empty stack, push+pop with 0xD0 -> count_o=1, top 0xD0, underflow_o pulse.
5. Stack {0x10, 0x20}, save slot 2. Pop, push 0x99, push 0x77; restore slot 2 -> next cycle count_o=2, top_data_o=0x20. Pop -> top 0x10.
6. Same-cycle flush+push -> count_o=0. Same-cycle restore+pop -> restore only. Save and restore of slot 1 in the same cycle -> old snapshot applied, new one stored. Assert rst_n_i mid-burst -> all outputs at reset values that cycle.
